// File: rtl/mux_sel.sv
// mux_sel: registered 2:1 bus select between addr (sel=1) and data (sel=0)
module mux_sel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] data,
    input  logic             sel,
    output logic [WIDTH-1:0] data_out
);
    always_ff @(posedge clk)
        data_out <= rst ? '0 : (sel ? addr : data);
endmodule

// File: tb/tb_mux_sel.sv
// tb_mux_sel: randomized scoreboard bench for the registered addr/data select
module tb_mux_sel;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = '0;
    logic [7:0] data = '0;
    logic       sel = 1'b0;
    logic [7:0] data_out;
    logic [7:0] exp_q[$];
    logic [7:0] ones_seen = '0;
    logic [7:0] zeros_seen = '0;
    int         vectors = 0;
    int         errors = 0;

    mux_sel dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .data(data),
        .sel(sel),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Reference: the word a bus reads after the edge, picked from the two sources by sel, reset wins
    function automatic logic [7:0] model(input logic r, input logic s, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] src[2];
        src[0] = d;
        src[1] = a;
        return r ? 8'h00 : src[s];
    endfunction

    task automatic apply(input logic r, input logic s, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rst  = r;
        sel  = s;
        addr = a;
        data = d;
        exp_q.push_back(model(r, s, a, d));
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                check("scoreboard", data_out, exp_q.pop_front());
                ones_seen  = ones_seen | data_out;
                zeros_seen = zeros_seen | ~data_out;
            end
        end
    end

    initial begin : stimulus
        int budget;
        apply(1, 1, 8'hAA, 8'hF4);
        apply(1, 1, 8'hAA, 8'hF4);
        apply(0, 1, 8'h50, 8'h90);
        apply(0, 0, 8'hAA, 8'hF4);
        apply(0, 1, 8'h5C, 8'hB3);
        apply(0, 1, 8'h5C, 8'h21);
        apply(0, 0, 8'h2E, 8'h5A);
        apply(0, 1, 8'h6B, 8'h1C);
        // Hold check: output captured 0x1C must not follow a mid-cycle sel change
        apply(0, 0, 8'h6B, 8'h1C);
        @(posedge clk);
        #3;
        sel = 1'b1;
        #1;
        check("hold_mid_cycle", data_out, 8'h1C);
        apply(0, 1, 8'h6B, 8'h1C);
        apply(1, 1, 8'h50, 8'h33);
        apply(0, 1, 8'h50, 8'h33);
        apply(0, 1, 8'hFF, 8'h00);
        apply(0, 0, 8'hFF, 8'h00);
        for (int i = 0; i < 400; i++)
            apply($urandom_range(0, 19) == 0, 1'($urandom), 8'($urandom), 8'($urandom));
        budget = 10;
        @(negedge clk);
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words never checked", exp_q.size());
        end
        check("bit_toggle", ones_seen & zeros_seen, 8'hFF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mux_sel.md
MUX_SEL -- requirements
Module: mux_sel

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of addr, data and data_out; the module SHALL instantiate with no parameter overrides.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: addr  input  WIDTH  address word presented for bus multiplexing.
REQ-005 Port: data  input  WIDTH  data word presented for bus multiplexing.
REQ-006 Port: sel  input  1  source select; 1 = addr, 0 = data.
REQ-007 Port: data_out  output  WIDTH  registered multiplexed bus word.
REQ-008 Port connection by name SHALL be supported for addr, data, data_out and sel; clk and rst are the only additional ports.

Function
REQ-009 On each rising clk edge with rst low, data_out SHALL load addr when sel is 1.
REQ-010 On each rising clk edge with rst low, data_out SHALL load data when sel is 0.
REQ-011 Latency: data_out SHALL reflect the inputs sampled at the previous rising edge, exactly 1 cycle, with no combinational path from any input to data_out.
REQ-012 Between rising edges, data_out SHALL hold its value regardless of input changes.
REQ-013 Simultaneous change of sel, addr and data before an edge: the single captured value SHALL be the one selected by the sel value sampled at that same edge.
REQ-014 The selection SHALL be a pure bit-for-bit copy, with no arithmetic, truncation or extension of the WIDTH-bit word.
REQ-015 sel as X or Z is out of contract.
REQ-016 addr and data values SHALL cover the full range 0x00 to 0xFF with no reserved codes.

Reset
REQ-017 When rst is high at a rising clk edge, data_out SHALL become all-zero (0x00) on that edge, independent of sel, addr and data.
REQ-018 rst SHALL take priority over the selection.
REQ-019 Reset asserted mid-operation SHALL clear data_out on the next edge.
REQ-020 After rst deasserts, the first rising edge with rst low SHALL load the selected input per REQ-009 and REQ-010.
REQ-021 Before the first reset, the value of data_out is undefined.

Structure
REQ-022 The module SHALL need no shared package; WIDTH is a module parameter and no typedefs are exported.
REQ-023 The module SHALL contain no sub-modules: one WIDTH-bit output register and a 2:1 select.

Verification
REQ-024 Reset: rst=1 for 2 cycles with addr=0xAA, data=0xF4, sel=1 -> data_out=0x00.
REQ-025 Select vectors, applied after reset, one per cycle:
- sel=1, addr=0x50, data=0x90 -> data_out=0x50 one cycle later.
- sel=0, addr=0xAA, data=0xF4 -> 0xF4.
- sel=1, addr=0x5C, data=0xB3 -> 0x5C.
- sel=1, addr=0x5C, data=0x21 -> 0x5C; data change is ignored while sel=1.
- sel=0, addr=0x2E, data=0x5A -> 0x5A.
- sel=1, addr=0x6B, data=0x1C -> 0x6B.
REQ-026 Latency check: toggle sel from 0 to 1 mid-cycle with addr=0x6B, data=0x1C -> data_out stays 0x1C until the next rising edge, then becomes 0x6B.
REQ-027 Reset mid-stream: sel=1, addr=0x50, rst=1 for 1 cycle -> data_out=0x00; after rst=0, next edge -> 0x50.
REQ-028 Extremes: addr=0xFF with sel=1 -> 0xFF; data=0x00 with sel=0 -> 0x00; the bench SHALL confirm every bit of data_out toggles.
